// File: rtl/soma_serial_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : soma_serial_pkg
//  Description : Shared types and helpers for the digit-serial adder.
//  Revision    : 1.0 - initial release
// ============================================================================
package soma_serial_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Digit counter width: clog2(WIDTH/DIGIT), never below one bit.
    function automatic int cnt_width(input int width, input int digit);
        int n;
        n = width / digit;
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage
`default_nettype wire

// File: rtl/soma_digit.sv
`default_nettype none
// ============================================================================
//  Module      : soma_digit
//  Description : Combinational DIGIT-bit ripple-carry adder.
//  Revision    : 1.0 - initial release
// ============================================================================
module soma_digit #(
    parameter int DIGIT = 2
) (
    input  logic [DIGIT-1:0] a,
    input  logic [DIGIT-1:0] b,
    input  logic             cin,
    output logic [DIGIT-1:0] sum,
    output logic             cout
);

    logic [DIGIT:0] w_c;

    assign w_c[0] = cin;

    for (genvar i = 0; i < DIGIT; i++) begin : g_fa
        assign sum[i]   = a[i] ^ b[i] ^ w_c[i];
        assign w_c[i+1] = (a[i] & b[i]) | (w_c[i] & (a[i] ^ b[i]));
    end

    assign cout = w_c[DIGIT];

endmodule
`default_nettype wire

// File: rtl/soma_serial.sv
`default_nettype none
// ============================================================================
//  Module      : soma_serial
//  Description : Digit-serial adder with start/busy/done handshake.
//  Revision    : 1.0 - initial release
// ============================================================================
module soma_serial
    import soma_serial_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DIGIT = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] s,
    output logic             cout
);

    localparam int c_n     = WIDTH / DIGIT;
    localparam int c_cnt_w = cnt_width(WIDTH, DIGIT);
    localparam logic [c_cnt_w-1:0] c_last = c_cnt_w'(c_n - 1);

    if ((DIGIT > WIDTH) || ((WIDTH % DIGIT) != 0)) begin : g_param_check
        $fatal(1, "soma_serial: WIDTH must be a positive multiple of DIGIT");
    end

    state_t             r_state;
    state_t             w_state_next;
    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_b;
    logic [WIDTH-1:0]   r_s;
    logic               r_cout;
    logic               r_carry;
    logic [c_cnt_w-1:0] r_cnt;

    logic               w_accept;
    logic               w_step;
    logic               w_last;
    logic [DIGIT-1:0]   w_dsum;
    logic               w_dcarry;
    logic [WIDTH-1:0]   w_s_next;

    soma_digit #(
        .DIGIT (DIGIT)
    ) u_digit (
        .a    (r_a[DIGIT-1:0]),
        .b    (r_b[DIGIT-1:0]),
        .cin  (r_carry),
        .sum  (w_dsum),
        .cout (w_dcarry)
    );

    // New digit enters at the top so the first digit lands at the bottom.
    if (DIGIT == WIDTH) begin : g_single
        assign w_s_next = w_dsum;
    end else begin : g_multi
        assign w_s_next = {w_dsum, r_s[WIDTH-1:DIGIT]};
    end

    assign w_last = (r_cnt == c_last);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        busy         = 1'b0;
        done         = 1'b0;
        w_accept     = 1'b0;
        w_step       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_accept     = 1'b1;
                    w_state_next = ST_RUN;
                end
            end
            ST_RUN: begin
                busy   = 1'b1;
                w_step = 1'b1;
                if (w_last) begin
                    w_state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                done = 1'b1;
                if (start) begin
                    w_accept     = 1'b1;
                    w_state_next = ST_RUN;
                end else begin
                    w_state_next = ST_IDLE;
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_a     <= '0;
            r_b     <= '0;
            r_s     <= '0;
            r_cout  <= 1'b0;
            r_carry <= 1'b0;
            r_cnt   <= '0;
        end else if (w_accept) begin
            r_a     <= a;
            r_b     <= b;
            r_carry <= cin;
            r_cnt   <= '0;
        end else if (w_step) begin
            r_a     <= r_a >> DIGIT;
            r_b     <= r_b >> DIGIT;
            r_s     <= w_s_next;
            r_carry <= w_dcarry;
            r_cnt   <= r_cnt + c_cnt_w'(1);
            if (w_last) begin
                r_cout <= w_dcarry;
            end
        end
    end

    assign s    = r_s;
    assign cout = r_cout;

endmodule
`default_nettype wire

// File: tb/tb_soma_serial.sv
`default_nettype none
// ============================================================================
//  Module      : tb_soma_serial
//  Description : Directed self-checking bench for soma_serial (DIGIT 2/1/8).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_soma_serial;

    logic       clk;
    logic       rst;
    logic       start_v [3];
    logic [7:0] a_v     [3];
    logic [7:0] b_v     [3];
    logic       cin_v   [3];
    logic       busy_v  [3];
    logic       done_v  [3];
    logic [7:0] s_v     [3];
    logic       cout_v  [3];

    int n_checks;
    int n_fail;
    int cyc;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Instance 0: DIGIT=2, instance 1: DIGIT=1, instance 2: DIGIT=8.
    soma_serial #(.WIDTH(8), .DIGIT(2)) u_dut_d2 (
        .clk(clk), .rst(rst), .start(start_v[0]), .a(a_v[0]), .b(b_v[0]),
        .cin(cin_v[0]), .busy(busy_v[0]), .done(done_v[0]), .s(s_v[0]), .cout(cout_v[0])
    );
    soma_serial #(.WIDTH(8), .DIGIT(1)) u_dut_d1 (
        .clk(clk), .rst(rst), .start(start_v[1]), .a(a_v[1]), .b(b_v[1]),
        .cin(cin_v[1]), .busy(busy_v[1]), .done(done_v[1]), .s(s_v[1]), .cout(cout_v[1])
    );
    soma_serial #(.WIDTH(8), .DIGIT(8)) u_dut_d8 (
        .clk(clk), .rst(rst), .start(start_v[2]), .a(a_v[2]), .b(b_v[2]),
        .cin(cin_v[2]), .busy(busy_v[2]), .done(done_v[2]), .s(s_v[2]), .cout(cout_v[2])
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Issues one operation from #1 after an edge; returns in the done cycle.
    task automatic op(input int k, input logic [7:0] av, input logic [7:0] bv,
                      input logic ci, input string tag, output int done_cyc);
        int         n_exp;
        int         lat;
        int         bcnt;
        logic [8:0] full;
        n_exp = (k == 0) ? 4 : ((k == 1) ? 8 : 1);
        full  = {1'b0, av} + {1'b0, bv} + {8'b0, ci};
        start_v[k] = 1'b1;
        a_v[k]     = av;
        b_v[k]     = bv;
        cin_v[k]   = ci;
        @(posedge clk);
        #1;
        start_v[k] = 1'b0;
        lat  = 0;
        bcnt = 0;
        while (!done_v[k] && lat < 40) begin
            if (busy_v[k]) bcnt++;
            @(posedge clk);
            #1;
            lat++;
        end
        done_cyc = cyc;
        check({tag, ".latency"}, lat, n_exp);
        check({tag, ".busy_cycles"}, bcnt, n_exp);
        check({tag, ".busy_in_done"}, {31'b0, busy_v[k]}, 0);
        check({tag, ".s"}, {24'b0, s_v[k]}, {24'b0, full[7:0]});
        check({tag, ".cout"}, {31'b0, cout_v[k]}, {31'b0, full[8]});
    endtask

    initial begin
        int         d1;
        int         d2;
        int         lat;
        logic       seen;
        logic [7:0] ra;
        logic [7:0] rb;
        logic       rc;

        n_checks = 0;
        n_fail   = 0;
        cyc      = 0;
        rst      = 1'b1;
        for (int k = 0; k < 3; k++) begin
            start_v[k] = 1'b0;
            a_v[k]     = 8'h00;
            b_v[k]     = 8'h00;
            cin_v[k]   = 1'b0;
        end
        idle(3);
        rst = 1'b0;
        idle(1);

        for (int k = 0; k < 3; k++) begin
            check($sformatf("reset%0d.busy", k), {31'b0, busy_v[k]}, 0);
            check($sformatf("reset%0d.done", k), {31'b0, done_v[k]}, 0);
            check($sformatf("reset%0d.s", k),    {24'b0, s_v[k]}, 0);
            check($sformatf("reset%0d.cout", k), {31'b0, cout_v[k]}, 0);
        end

        // Basic, full-ripple and carry-in cases.
        op(0, 8'h37, 8'h48, 1'b0, "add_37_48", d1);
        check("add_37_48.s_const", {24'b0, s_v[0]}, 32'h7F);
        idle(1);
        op(0, 8'hFF, 8'h01, 1'b0, "add_ff_01", d1);
        check("add_ff_01.cout_const", {31'b0, cout_v[0]}, 1);
        idle(1);
        op(0, 8'hA5, 8'h5A, 1'b1, "add_a5_5a_c", d1);
        for (int i = 0; i < 3; i++) begin
            idle(1);
            check($sformatf("hold%0d.done", i), {31'b0, done_v[0]}, 0);
            check($sformatf("hold%0d.s", i),    {24'b0, s_v[0]}, 32'h00);
            check($sformatf("hold%0d.cout", i), {31'b0, cout_v[0]}, 1);
        end

        // Start pulsed mid-RUN must be ignored.
        start_v[0] = 1'b1;
        a_v[0]     = 8'h10;
        b_v[0]     = 8'h20;
        cin_v[0]   = 1'b0;
        idle(1);
        start_v[0] = 1'b0;
        idle(1);
        start_v[0] = 1'b1;
        a_v[0]     = 8'hFF;
        b_v[0]     = 8'hFF;
        idle(1);
        start_v[0] = 1'b0;
        lat = 2;
        while (!done_v[0] && lat < 40) begin
            idle(1);
            lat++;
        end
        check("ignore.latency", lat, 4);
        check("ignore.s",    {24'b0, s_v[0]}, 32'h30);
        check("ignore.cout", {31'b0, cout_v[0]}, 0);
        idle(1);
        check("ignore.idle_busy", {31'b0, busy_v[0]}, 0);
        check("ignore.idle_done", {31'b0, done_v[0]}, 0);

        // Reset in the third RUN cycle discards the operation.
        start_v[0] = 1'b1;
        a_v[0]     = 8'hF0;
        b_v[0]     = 8'h0F;
        idle(1);
        start_v[0] = 1'b0;
        idle(2);
        rst = 1'b1;
        idle(1);
        rst = 1'b0;
        check("midrst.busy", {31'b0, busy_v[0]}, 0);
        check("midrst.done", {31'b0, done_v[0]}, 0);
        check("midrst.s",    {24'b0, s_v[0]}, 0);
        check("midrst.cout", {31'b0, cout_v[0]}, 0);
        seen = 1'b0;
        for (int i = 0; i < 5; i++) begin
            idle(1);
            if (done_v[0] || busy_v[0]) seen = 1'b1;
        end
        check("midrst.no_activity", {31'b0, seen}, 0);
        op(0, 8'h01, 8'h01, 1'b0, "add_01_01", d1);
        check("add_01_01.s_const", {24'b0, s_v[0]}, 32'h02);
        idle(1);

        // Back-to-back: second start presented in the DONE cycle.
        op(0, 8'h12, 8'h34, 1'b0, "b2b_d2_first", d1);
        op(0, 8'h99, 8'h88, 1'b1, "b2b_d2_second", d2);
        check("b2b_d2.gap", d2 - d1, 5);
        check("b2b_d2.s_const", {24'b0, s_v[0]}, 32'h22);
        idle(1);

        for (int k = 1; k < 3; k++) begin
            for (int r = 0; r < 3; r++) begin
                ra = 8'($urandom_range(0, 255));
                rb = 8'($urandom_range(0, 255));
                rc = 1'($urandom_range(0, 1));
                op(k, ra, rb, rc, $sformatf("rnd%0d_%0d_a", k, r), d1);
                ra = 8'($urandom_range(0, 255));
                rb = 8'($urandom_range(0, 255));
                rc = 1'($urandom_range(0, 1));
                op(k, ra, rb, rc, $sformatf("rnd%0d_%0d_b", k, r), d2);
                check($sformatf("rnd%0d_%0d.gap", k, r), d2 - d1, (k == 1) ? 9 : 2);
                idle(1);
            end
        end

        // Corner operands for the degenerate single-digit instance.
        op(2, 8'hFF, 8'hFF, 1'b1, "d8_max", d1);
        check("d8_max.s_const", {24'b0, s_v[2]}, 32'hFF);
        idle(1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
